// File: rtl/dmem_resp.sv
// MEM-stage data memory responder: backing store with configurable read/write
// latency, a pipeline stall request while busy, and an rd+wr collision flag.
module dmem_resp #(
  parameter int unsigned AW     = 7,
  parameter int unsigned DW     = 32,
  parameter int unsigned NWORDS = 128,
  parameter int unsigned RD_LAT = 2,
  parameter int unsigned WR_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] addr,
  input  logic          rd,
  input  logic          wr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          rvalid,
  output logic          stall,
  output logic          err
);

  typedef enum logic [1:0] {
    IDLE,
    RBUSY,
    WBUSY
  } state_t;

  localparam logic [3:0] RD_INIT = 4'(RD_LAT - 1);
  localparam logic [3:0] WR_INIT = 4'(WR_LAT - 1);

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [AW-1:0]   areg_q, areg_d;
  logic [DW-1:0]   dreg_q, dreg_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            err_q, err_d;

  logic            stall_c;
  logic            rvalid_c;
  logic            mem_we;
  logic [AW-1:0]   mem_wa;
  logic [DW-1:0]   mem_wd;

  logic [DW-1:0]   mem [NWORDS];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    areg_d   = areg_q;
    dreg_d   = dreg_q;
    rdata_d  = rdata_q;
    err_d    = 1'b0;
    stall_c  = 1'b0;
    rvalid_c = 1'b0;
    mem_we   = 1'b0;
    mem_wa   = areg_q;
    mem_wd   = dreg_q;

    unique case (state_q)
      IDLE: begin
        if (wr) begin
          // Write wins a collision; the read half is dropped and flagged.
          err_d  = rd;
          areg_d = addr;
          dreg_d = wdata;
          if (WR_LAT == 0) begin
            mem_we = 1'b1;
            mem_wa = addr;
            mem_wd = wdata;
          end else begin
            stall_c = 1'b1;
            state_d = WBUSY;
            cnt_d   = WR_INIT;
          end
        end else if (rd) begin
          stall_c = 1'b1;
          areg_d  = addr;
          dreg_d  = wdata;
          state_d = RBUSY;
          cnt_d   = RD_INIT;
          if (RD_LAT == 1) begin
            rdata_d = mem[addr];
          end
        end
      end

      RBUSY: begin
        if (cnt_q == 4'd0) begin
          rvalid_c = 1'b1;
          state_d  = IDLE;
        end else begin
          stall_c = 1'b1;
          cnt_d   = cnt_q - 4'd1;
          // Data lands one edge before the completion cycle.
          if (cnt_q == 4'd1) begin
            rdata_d = mem[areg_q];
          end
        end
      end

      WBUSY: begin
        if (cnt_q == 4'd0) begin
          mem_we  = 1'b1;
          state_d = IDLE;
        end else begin
          stall_c = 1'b1;
          cnt_d   = cnt_q - 4'd1;
        end
      end

      default: state_d = IDLE;
    endcase

    // A write must never commit while reset is held.
    if (reset) begin
      mem_we = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      areg_q  <= '0;
      dreg_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      areg_q  <= areg_d;
      dreg_q  <= dreg_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_wa] <= mem_wd;
    end
  end

  assign stall  = stall_c & ~reset;
  assign rvalid = rvalid_c & ~reset;
  assign rdata  = rdata_q;
  assign err    = err_q;

endmodule
